// File: rtl/ipf_pkg.sv
// Shared definitions for the IPF pipeline: frame geometry, LCU size codes,
// FSM state encoding and the parameter-word layout.
package ipf_pkg;

    localparam int IMG_W  = 128;
    localparam int CW     = $clog2(IMG_W);
    localparam int PAR_W  = 24;
    localparam int FIFO_D = 2;

    typedef enum logic [1:0] {
        LCU_16     = 2'd0,
        LCU_32     = 2'd1,
        LCU_64     = 2'd2,
        LCU_64_ALT = 2'd3
    } lcu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREQ,
        ST_PLOAD,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Field order matches the parameter word, MSB first.
    typedef struct packed {
        logic [1:0]  typ;
        logic [4:0]  band_pos;
        logic        wo_class;
        logic [15:0] offset;
    } par_word_t;

    function automatic logic [1:0] norm_size(input logic [1:0] s);
        return (s == LCU_64_ALT) ? 2'(LCU_64) : s;
    endfunction

endpackage

// File: rtl/ipf_fifo2.sv
// Two-entry synchronous FIFO holding returned pixels between the image
// memory and IPF; push and pop may occur in the same cycle.
module ipf_fifo2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic [1:0] occ
);

    logic [7:0] mem [2];
    logic       wr_ptr;
    logic       rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: storage is reset so the head (and thus din) reads 0 after reset.
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            occ <= occ + 2'(push) - 2'(pop);
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/ipf_lcu_feeder.sv
// Fetches a frame LCU by LCU in raster order and streams each LCU's pixels
// row-major into IPF, holding that LCU's filter parameters on the config ports.
module ipf_lcu_feeder
    import ipf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        cfg_lcu_size,
    output logic              img_rd,
    output logic [2*CW-1:0]   img_addr,
    input  logic [7:0]        img_q,
    output logic              par_rd,
    output logic [5:0]        par_addr,
    input  logic [PAR_W-1:0]  par_q,
    input  logic              busy,
    output logic              in_en,
    output logic [7:0]        din,
    output logic [1:0]        ipf_type,
    output logic [4:0]        ipf_band_pos,
    output logic              ipf_wo_class,
    output logic [15:0]       ipf_offset,
    output logic [2:0]        lcu_x,
    output logic [2:0]        lcu_y,
    output logic [1:0]        lcu_size,
    output logic              done
);

    state_e     state;
    logic [5:0] px, py;
    logic [2:0] lx, ly;
    logic       inflight;
    logic [1:0] occ;
    logic       fifo_empty;
    logic [5:0] n_last;
    logic [2:0] l_last;
    logic [6:0] img_x, img_y;
    logic       credit_ok;
    logic       last_lcu;
    par_word_t  par_w;

    assign n_last = 6'((7'd16 << lcu_size) - 7'd1);
    assign l_last = 3'((4'd8 >> lcu_size) - 4'd1);
    assign img_x  = (7'({lx, 4'b0000}) << lcu_size) + 7'(px);
    assign img_y  = (7'({ly, 4'b0000}) << lcu_size) + 7'(py);
    assign img_addr = {img_y, img_x};
    assign par_addr = (6'(ly) << (2'd3 - lcu_size)) + 6'(lx);
    assign par_w    = par_word_t'(par_q);
    assign last_lcu = (lx == l_last) && (ly == l_last);

    assign fifo_empty = (occ == 2'd0);
    assign in_en      = !fifo_empty && !busy;

    // A read is issued only if its data is guaranteed a FIFO slot on return.
    assign credit_ok = (3'(occ) + 3'(inflight) - 3'(in_en)) < 3'(FIFO_D);
    assign img_rd    = (state == ST_STREAM) && credit_ok;
    assign par_rd    = (state == ST_PREQ) && fifo_empty && !inflight && !busy;

    ipf_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .wdata (img_q),
        .pop   (in_en),
        .rdata (din),
        .occ   (occ)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            px           <= '0;
            py           <= '0;
            lx           <= '0;
            ly           <= '0;
            inflight     <= 1'b0;
            ipf_type     <= '0;
            ipf_band_pos <= '0;
            ipf_wo_class <= 1'b0;
            ipf_offset   <= '0;
            lcu_x        <= '0;
            lcu_y        <= '0;
            lcu_size     <= '0;
            done         <= 1'b0;
        end else begin
            inflight <= img_rd;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lcu_size <= norm_size(cfg_lcu_size);
                        state    <= ST_PREQ;
                    end
                end
                ST_PREQ: begin
                    if (par_rd)
                        state <= ST_PLOAD;
                end
                ST_PLOAD: begin
                    ipf_type     <= par_w.typ;
                    ipf_band_pos <= par_w.band_pos;
                    ipf_wo_class <= par_w.wo_class;
                    ipf_offset   <= par_w.offset;
                    lcu_x        <= lx;
                    lcu_y        <= ly;
                    state        <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (img_rd) begin
                        if (px == n_last) begin
                            px <= '0;
                            if (py == n_last) begin
                                py    <= '0;
                                state <= ST_DRAIN;
                            end else begin
                                py <= py + 6'd1;
                            end
                        end else begin
                            px <= px + 6'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty && !inflight) begin
                        if (last_lcu) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            if (lx == l_last) begin
                                lx <= '0;
                                ly <= ly + 3'd1;
                            end else begin
                                lx <= lx + 3'd1;
                            end
                            state <= ST_PREQ;
                        end
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        lcu_size <= norm_size(cfg_lcu_size);
                        px       <= '0;
                        py       <= '0;
                        lx       <= '0;
                        ly       <= '0;
                        done     <= 1'b0;
                        state    <= ST_PREQ;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ipf_lcu_feeder.sv
// Scoreboard bench for ipf_lcu_feeder: a frame-level reference model fills the
// expected pixel queue, and a monitor pops and compares on every in_en.
module tb_ipf_lcu_feeder;
    import ipf_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  cfg_lcu_size = 2'd0;
    logic        img_rd;
    logic [13:0] img_addr;
    logic [7:0]  img_q = 8'd0;
    logic        par_rd;
    logic [5:0]  par_addr;
    logic [23:0] par_q = 24'd0;
    logic        busy = 1'b0;
    logic        in_en;
    logic [7:0]  din;
    logic [1:0]  ipf_type;
    logic [4:0]  ipf_band_pos;
    logic        ipf_wo_class;
    logic [15:0] ipf_offset;
    logic [2:0]  lcu_x, lcu_y;
    logic [1:0]  lcu_size;
    logic        done;

    ipf_lcu_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_lcu_size (cfg_lcu_size),
        .img_rd       (img_rd),
        .img_addr     (img_addr),
        .img_q        (img_q),
        .par_rd       (par_rd),
        .par_addr     (par_addr),
        .par_q        (par_q),
        .busy         (busy),
        .in_en        (in_en),
        .din          (din),
        .ipf_type     (ipf_type),
        .ipf_band_pos (ipf_band_pos),
        .ipf_wo_class (ipf_wo_class),
        .ipf_offset   (ipf_offset),
        .lcu_x        (lcu_x),
        .lcu_y        (lcu_y),
        .lcu_size     (lcu_size),
        .done         (done)
    );

    always #5 clk = ~clk;

    logic [7:0]  img_mem [16384];
    logic [23:0] par_mem [64];

    // Memories with one cycle of read latency.
    always @(posedge clk) begin
        if (img_rd) img_q <= img_mem[img_addr];
        if (par_rd) par_q <= par_mem[par_addr];
    end

    logic busy_force = 1'b0;
    logic busy_rand  = 1'b0;
    always @(posedge clk) begin
        #1;
        busy = busy_force || (busy_rand && ($urandom_range(0, 1) == 1));
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Expected entry: {pixel, lcu_x, lcu_y, lcu_size, param word, done}.
    logic [40:0] sb_q [$];
    logic [7:0]  cap_q [$];
    logic [10:0] lcu_seq [$];
    int          pix_cnt = 0;
    logic        capture = 1'b0;
    logic        rec_lcu = 1'b0;
    logic [40:0] mon_exp;
    logic [10:0] mon_tag;

    always @(negedge clk) begin
        if (!rst && in_en) begin
            check("in_en_while_busy", 64'(busy), 64'd0);
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pixel: din %h with empty scoreboard", din);
            end else begin
                mon_exp = sb_q.pop_front();
                check("pixel", 64'({din, lcu_x, lcu_y, lcu_size, ipf_type, ipf_band_pos,
                                    ipf_wo_class, ipf_offset, done}), 64'(mon_exp));
            end
            pix_cnt++;
            if (capture) cap_q.push_back(din);
            mon_tag = {lcu_x, lcu_y, ipf_band_pos};
            if (rec_lcu && (lcu_seq.size() == 0 || lcu_seq[$] != mon_tag))
                lcu_seq.push_back(mon_tag);
        end
    end

    // Reference model: LCUs in raster order, pixels row-major inside each LCU.
    task automatic build_frame(input int cfg);
        int s, n, nl;
        s  = (cfg == 3) ? 2 : cfg;
        n  = 16 << s;
        nl = 8 >> s;
        for (int ly = 0; ly < nl; ly++)
            for (int lx = 0; lx < nl; lx++)
                for (int py = 0; py < n; py++)
                    for (int px = 0; px < n; px++) begin
                        int x, y;
                        x = lx * n + px;
                        y = ly * n + py;
                        sb_q.push_back({img_mem[y * 128 + x], 3'(lx), 3'(ly), 2'(s),
                                        par_mem[ly * nl + lx], 1'b0});
                    end
    endtask

    function automatic logic [63:0] all_outputs();
        return {img_rd, img_addr, par_rd, par_addr, in_en, din, ipf_type, ipf_band_pos,
                ipf_wo_class, ipf_offset, lcu_x, lcu_y, lcu_size, done};
    endfunction

    task automatic start_frame(input logic [1:0] cfg);
        @(posedge clk); #2;
        cfg_lcu_size = cfg;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        cfg_lcu_size = 2'($urandom);
    endtask

    task automatic wait_frame(input string name, input int budget);
        int i;
        i = 0;
        while ((sb_q.size() != 0 || !done) && i < budget) begin
            @(negedge clk);
            i++;
        end
        check({name, "_done"}, 64'(done), 64'd1);
        check({name, "_remaining"}, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic wait_pixels(input int cnt, input int budget);
        int base, i;
        base = pix_cnt;
        i = 0;
        while (pix_cnt - base < cnt && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("pixel_wait", 64'(pix_cnt - base >= cnt), 64'd1);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16384; i++) img_mem[i] = 8'($urandom);
        for (int i = 0; i < 64; i++) par_mem[i] = 24'($urandom);
    endtask

    initial begin
        int n_en, n_rd;
        logic last_rd;

        // Reset state
        fill_random();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 check("reset_outputs", all_outputs(), 64'd0);
        @(posedge clk); #2 rst = 1'b0;

        // Frame A: size 0, pixel = (x+y)&255, busy held 20 cycles mid-row
        for (int y = 0; y < 128; y++)
            for (int x = 0; x < 128; x++) img_mem[y * 128 + x] = 8'((x + y) & 255);
        capture = 1'b1;
        build_frame(0);
        start_frame(2'd0);
        wait_pixels(40, 2000);
        @(posedge clk); #2 busy_force = 1'b1;
        @(posedge clk); #2;
        n_en = 0;
        n_rd = 0;
        last_rd = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (in_en) n_en++;
            if (img_rd) n_rd++;
            last_rd = img_rd;
        end
        busy_force = 1'b0;
        check("busy_hold_in_en", 64'(n_en), 64'd0);
        check("busy_hold_rd_le2", 64'(n_rd <= 2), 64'd1);
        check("busy_hold_rd_stopped", 64'(last_rd), 64'd0);
        wait_frame("frame_a", 30000);
        capture = 1'b0;
        check("frame_a_count", 64'(cap_q.size()), 64'd16384);
        if (cap_q.size() > 256) begin
            for (int i = 0; i < 16; i++) check("first_row", 64'(cap_q[i]), 64'(i));
            check("second_row_first", 64'(cap_q[16]), 64'd1);
            check("lcu1_first", 64'(cap_q[256]), 64'd16);
        end

        // Frame B: cfg 3 behaves as size 2, band_pos follows LCU index
        fill_random();
        for (int i = 0; i < 64; i++) par_mem[i] = {2'd1, 5'(i), 1'b0, 16'h1234};
        rec_lcu = 1'b1;
        build_frame(3);
        start_frame(2'd3);
        @(negedge clk);
        check("cfg3_lcu_size", 64'(lcu_size), 64'd2);
        wait_frame("frame_b", 30000);
        rec_lcu = 1'b0;
        check("frame_b_lcu_count", 64'(lcu_seq.size()), 64'd4);
        for (int i = 0; i < 4 && i < lcu_seq.size(); i++)
            check("frame_b_lcu", 64'(lcu_seq[i]), 64'({3'(i % 2), 3'(i / 2), 5'(i)}));

        // Frame C: size 1 with random 50% busy
        fill_random();
        busy_rand = 1'b1;
        build_frame(1);
        start_frame(2'd1);
        wait_frame("frame_c", 80000);
        busy_rand = 1'b0;

        // Reset at pixel 500 of a size-0 frame, then restart from (0,0)
        fill_random();
        build_frame(0);
        start_frame(2'd0);
        wait_pixels(500, 3000);
        @(posedge clk); #2 rst = 1'b1;
        #1 check("mid_reset_outputs", all_outputs(), 64'd0);
        sb_q.delete();
        @(posedge clk); #2 rst = 1'b0;
        build_frame(2);
        start_frame(2'd2);
        wait_pixels(300, 3000);
        @(posedge clk); #2 rst = 1'b1;
        #1 check("final_reset_outputs", all_outputs(), 64'd0);
        sb_q.delete();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
